rom_burst_reader: RTL
=====================

Name: rom_burst_reader

Overview:
- Parametrised, handshaked successor to the fixed-content, single-address registered ROM.
- Accepts burst read requests (start address, length, wrap mode) on a valid/ready port.
- Streams one registered ROM word per cycle on a valid/ready response port, with full backpressure and a last-word marker.
- Sits between a command sequencer and any consumer of constant tables (coefficients, microcode, lookup data).

Parameters:
- DATA_WIDTH, 9: width of each ROM word.
- DEPTH, 5: number of words; legal range 2..1024.
- ADDR_WIDTH, $clog2(DEPTH): address width; derived, not overridden.
- LEN_WIDTH, 4: width of the burst length field; burst is req_len+1 words.
- CONTENTS, all zeros: packed vector of DEPTH*DATA_WIDTH bits; word i is CONTENTS[i*DATA_WIDTH +: DATA_WIDTH].

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- req_valid  input  1  burst request valid.
- req_ready  output  1  burst request accepted when high together with req_valid.
- req_addr  input  ADDR_WIDTH  start word address.
- req_len  input  LEN_WIDTH  number of words minus one.
- req_wrap  input  1  1: address wraps DEPTH-1 -> 0; 0: no wrap, out-of-range words are flagged.
- rsp_valid  output  1  response word valid.
- rsp_ready  input  1  consumer accepts the response word.
- rsp_data  output  DATA_WIDTH  registered ROM word.
- rsp_last  output  1  final word of the burst.
- rsp_err  output  1  word address was >= DEPTH; rsp_data is 0 for that word.
- busy  output  1  a burst is in progress (state READ).

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; rsp_valid, rsp_data, rsp_last, rsp_err, busy all 0.
  - Internal pointer, remaining count and oob flag cleared.
  - req_ready is 1 on the first edge after release.
- Reset during a burst aborts it: the current word is dropped and no further responses are produced.
- advance = !rsp_valid || rsp_ready. The output register loads only when advance is high. Holding rsp_ready low freezes rsp_* and stalls fetch; nothing is dropped or duplicated.
- FSM states: IDLE, READ.
  - IDLE: req_ready=1. On accept, capture ptr=req_addr, rem=req_len, wrap=req_wrap, oob=(req_addr>=DEPTH), then go to READ.
  - READ: when advance is high, issue the word at ptr into the output register, then set ptr=next(ptr) and rem=rem-1.
  - READ, word with rem==0: rsp_last=1. If req_valid is high in that cycle, the new request is accepted with no bubble (req_ready=advance when rem==0; otherwise req_ready=0). With no new request, go to IDLE.
- Latency: request accepted at edge T -> first word has rsp_valid=1 after edge T+1. Throughput is 1 word/cycle while rsp_ready=1.
- next(ptr):
  - wrap=1 and ptr==DEPTH-1 -> 0.
  - wrap=0 and ptr==DEPTH-1 -> set oob sticky for the rest of the burst.
  - Otherwise ptr+1.
- Issued word:
  - oob=0: rsp_data=CONTENTS word, rsp_err=0.
  - oob=1: rsp_data=0, rsp_err=1.
- After a word is consumed with no pending word, rsp_valid drops to 0 on the next edge. rsp_data holds its last value.
- req_* inputs are sampled only on accept; changes at any other time are ignored.
- DEPTH that is not a power of 2: req_addr>=DEPTH sets oob immediately. In wrap mode that whole burst is flagged; the pointer is not forced into range.

Decomposition:
- Package rom_burst_pkg: state enum (IDLE, READ) and a localparam helper function computing the CONTENTS word slice.
- One sub-module, rom_burst_lookup: combinational; address -> word plus out-of-range flag; parametrised by DATA_WIDTH, DEPTH, CONTENTS.
- FSM, pointer, counter and output register live in rom_burst_reader.

Test Plan:
All cases use DATA_WIDTH=9, DEPTH=5, CONTENTS={1FF,0FF,000,101,1FB} (words 4..0).
1. Reset mid-burst: req addr=0 len=4 wrap=1; assert rst_b low at word 2 -> all outputs 0 immediately, req_ready=1 after release, no further rsp.
2. Single-word read: req addr=1 len=0, rsp_ready=1 -> one cycle later rsp_data=101, rsp_last=1, rsp_err=0; busy low after.
3. Wrapped burst: addr=3 len=3 wrap=1 -> 0FF,1FF,1FB,101 on consecutive cycles; rsp_last only on 101.
4. Non-wrap overrun: addr=3 len=3 wrap=0 -> 0FF/err0, 1FF/err0, 000/err1, 000/err1 with rsp_last on the 4th word.
5. Backpressure: addr=0 len=2, rsp_ready toggling 1,0,0,1,1 -> rsp_data holds stable while stalled; sequence 1FB,101,000 delivered exactly once.
6. Back-to-back: second request (addr=4 len=0) valid during the last word of the first burst -> accepted that cycle, 1FF follows with no idle cycle.

Source files
------------

// File: rtl/rom_burst_pkg.sv
// Shared types and helpers for the burst-reading ROM.
package rom_burst_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    // LSB position of word idx inside the flat CONTENTS vector.
    function automatic int word_lsb(int idx, int width);
        return idx * width;
    endfunction

    // True when a word address falls outside the populated ROM.
    function automatic logic addr_oob(int addr, int depth);
        return addr >= depth;
    endfunction

endpackage

// File: rtl/rom_burst_lookup.sv
// Combinational ROM lookup: word address -> stored word plus out-of-range flag.
// Addresses beyond DEPTH read back as zero.
module rom_burst_lookup
    import rom_burst_pkg::*;
#(
    parameter int                            DATA_WIDTH = 9,
    parameter int                            DEPTH      = 5,
    parameter logic [DEPTH*DATA_WIDTH-1:0]   CONTENTS   = '0
) (
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     oor_o
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int SLOTS      = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rom [SLOTS];

    // Unpack CONTENTS into a full power-of-two table, zero-filling the unused tail.
    for (genvar i = 0; i < SLOTS; i++) begin : g_rom
        if (i < DEPTH) begin : g_word
            assign rom[i] = CONTENTS[word_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
        end else begin : g_pad
            assign rom[i] = '0;
        end
    end

    assign data_o = rom[addr_i];
    assign oor_o  = addr_oob(int'(addr_i), DEPTH);

endmodule

// File: rtl/rom_burst_reader.sv
// Burst reader over a constant ROM: accepts (addr, len, wrap) requests and
// streams one registered word per cycle with backpressure and a last marker.
module rom_burst_reader
    import rom_burst_pkg::*;
#(
    parameter int                            DATA_WIDTH = 9,
    parameter int                            DEPTH      = 5,
    parameter int                            ADDR_WIDTH = $clog2(DEPTH),
    parameter int                            LEN_WIDTH  = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0]   CONTENTS   = '0
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  req_wrap,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                  state_q;
    logic                    ready_en_q;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]    rem_q;
    logic                    wrap_q;
    logic                    oob_q, oob_d;
    logic                    rsp_valid_q, rsp_last_q, rsp_err_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;

    logic [DATA_WIDTH-1:0]   rom_word;
    logic                    rom_oor;
    logic                    word_err;
    logic                    advance;
    logic                    accept;

    rom_burst_lookup #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CONTENTS   (CONTENTS)
    ) u_lookup (
        .addr_i (ptr_q),
        .data_o (rom_word),
        .oor_o  (rom_oor)
    );

    // Output register may load when empty or when its word is being taken.
    assign advance  = !rsp_valid_q || rsp_ready;
    assign word_err = oob_q || rom_oor;
    // Last-word cycle doubles as an accept slot so bursts chain without a bubble.
    assign req_ready = ready_en_q &&
                       ((state_q == IDLE) || ((rem_q == '0) && advance));
    assign accept    = req_valid && req_ready;

    // Next pointer: wrap to 0 or, in linear mode, run off the end and go sticky-oob.
    always_comb begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        oob_d = oob_q;
        if (ptr_q == LAST_ADDR) begin
            if (wrap_q) ptr_d = '0;
            else        oob_d = 1'b1;
        end
    end

    // FSM, burst bookkeeping and the registered response stage.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            ready_en_q  <= 1'b0;
            ptr_q       <= '0;
            rem_q       <= '0;
            wrap_q      <= 1'b0;
            oob_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (advance) rsp_valid_q <= 1'b0;

            if (state_q == READ && advance) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= word_err ? '0 : rom_word;
                rsp_err_q   <= word_err;
                rsp_last_q  <= (rem_q == '0);
                if (rem_q != '0) begin
                    rem_q <= rem_q - LEN_WIDTH'(1);
                    ptr_q <= ptr_d;
                    oob_q <= oob_d;
                end else begin
                    state_q <= IDLE;
                end
            end

            // A new burst overrides the IDLE transition above.
            if (accept) begin
                state_q <= READ;
                ptr_q   <= req_addr;
                rem_q   <= req_len;
                wrap_q  <= req_wrap;
                oob_q   <= addr_oob(int'(req_addr), DEPTH);
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q == READ);

endmodule
